// File: rtl/ita_bridge_pkg.sv
// Shared definitions for the ITA peripheral bridge: FSM encoding, default
// slave region decode constants and the error-completion read data.
package ita_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } ita_state_e;

  localparam logic [31:0] ITA_SLV0_BASE = 32'h1000_0000;
  localparam logic [31:0] ITA_SLV0_MASK = 32'hFFFF_F000;
  localparam logic [31:0] ITA_SLV1_BASE = 32'h1000_1000;
  localparam logic [31:0] ITA_SLV1_MASK = 32'hFFFF_F000;

  // Read data returned on error completions (sliced to XLEN by users)
  localparam logic [63:0] ITA_ERR_RDATA = 64'h0;

  // A command is legal when exactly one of write/read is requested
  function automatic logic ita_cmd_legal(input logic wr, input logic rd);
    return wr ^ rd;
  endfunction

endpackage

// File: rtl/ita_addr_dec.sv
// Combinational two-region address decoder: one-hot slave select plus miss
// flag. Slave 0 has priority when both regions match.
module ita_addr_dec
  import ita_bridge_pkg::*;
#(
  parameter int              AW      = 32,
  parameter logic [AW-1:0]   S0_BASE = AW'(ITA_SLV0_BASE),
  parameter logic [AW-1:0]   S0_MASK = AW'(ITA_SLV0_MASK),
  parameter logic [AW-1:0]   S1_BASE = AW'(ITA_SLV1_BASE),
  parameter logic [AW-1:0]   S1_MASK = AW'(ITA_SLV1_MASK)
) (
  input  logic [AW-1:0] addr,
  output logic [1:0]    sel,
  output logic          miss
);

  logic hit0_s;
  logic hit1_s;

  assign hit0_s = ((addr & S0_MASK) == S0_BASE);
  assign hit1_s = ((addr & S1_MASK) == S1_BASE);
  assign miss   = ~(hit0_s | hit1_s);

  // Priority-encode the region hits into a one-hot select
  always_comb begin
    sel = 2'b00;
    if (hit0_s) begin
      sel = 2'b01;
    end else if (hit1_s) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
  end

endmodule

// File: rtl/ita_bridge.sv
// ITA peripheral bridge: accepts one LSU non-RAM access, decodes it to one of
// two slaves, forwards it with valid/ready and returns a one-cycle completion.
// Decode misses, illegal commands and slave timeouts complete with zero data
// and are logged in sticky error registers.
// Optional feature macro: ITA_TIMEOUT_EN (REQ timeout counter and abort).
module ita_bridge
  import ita_bridge_pkg::*;
#(
  parameter int                 PC_SIZE   = 32,
  parameter int                 XLEN      = 32,
  parameter logic [PC_SIZE-1:0] SLV0_BASE = PC_SIZE'(ITA_SLV0_BASE),
  parameter logic [PC_SIZE-1:0] SLV0_MASK = PC_SIZE'(ITA_SLV0_MASK),
  parameter logic [PC_SIZE-1:0] SLV1_BASE = PC_SIZE'(ITA_SLV1_BASE),
  parameter logic [PC_SIZE-1:0] SLV1_MASK = PC_SIZE'(ITA_SLV1_MASK),
  parameter int                 TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ita_i_valid,
  input  logic               ita_i_wr,
  input  logic               ita_i_rd,
  input  logic [PC_SIZE-1:0] ita_i_addr,
  input  logic [XLEN-1:0]    ita_i_wdata,
  output logic [XLEN-1:0]    ita_o_rdata,
  output logic               ita_o_ready,
  output logic [1:0]         slv_o_sel,
  output logic               slv_o_valid,
  output logic               slv_o_wr,
  output logic               slv_o_rd,
  output logic [PC_SIZE-1:0] slv_o_addr,
  output logic [XLEN-1:0]    slv_o_wdata,
  input  logic [XLEN-1:0]    slv0_i_rdata,
  input  logic [XLEN-1:0]    slv1_i_rdata,
  input  logic               slv0_i_ready,
  input  logic               slv1_i_ready,
  input  logic               err_i_clr,
  output logic               bridge_o_err,
  output logic [PC_SIZE-1:0] bridge_o_err_addr
);

  localparam logic [XLEN-1:0] ERR_RDATA = ITA_ERR_RDATA[XLEN-1:0];

  ita_state_e         state_r, state_nxt;
  logic [1:0]         sel_r, sel_nxt, dec_sel_s;
  logic               dec_miss_s;
  logic               valid_r, ready_r;
  logic [XLEN-1:0]    rdata_r, rdata_nxt;
  logic               wr_r, rd_r;
  logic [PC_SIZE-1:0] addr_r;
  logic [XLEN-1:0]    wdata_r;
  logic               err_r, err_set_s;
  logic [PC_SIZE-1:0] err_addr_r, err_addr_s;
  logic               slv_ready_s;
  logic [XLEN-1:0]    slv_rdata_s;
  logic               tmo_hit_s;

  ita_addr_dec #(
    .AW      (PC_SIZE),
    .S0_BASE (SLV0_BASE),
    .S0_MASK (SLV0_MASK),
    .S1_BASE (SLV1_BASE),
    .S1_MASK (SLV1_MASK)
  ) u_dec (
    .addr (ita_i_addr),
    .sel  (dec_sel_s),
    .miss (dec_miss_s)
  );

  // Only the selected slave is observed; sel_r is zero outside REQ
  assign slv_ready_s = (sel_r[0] & slv0_i_ready) | (sel_r[1] & slv1_i_ready);
  assign slv_rdata_s = sel_r[0] ? slv0_i_rdata : slv1_i_rdata;

`ifdef ITA_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Count REQ cycles; zero whenever not in REQ so each entry starts fresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r == ST_REQ) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end
  end

  assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state, next-output and error-event decode
  always_comb begin
    state_nxt  = state_r;
    sel_nxt    = 2'b00;
    rdata_nxt  = ERR_RDATA;
    err_set_s  = 1'b0;
    err_addr_s = addr_r;
    case (state_r)
      ST_IDLE: begin
        if (ita_i_valid) begin
          if (dec_miss_s || !ita_cmd_legal(ita_i_wr, ita_i_rd)) begin
            state_nxt  = ST_RESP;
            err_set_s  = 1'b1;
            err_addr_s = ita_i_addr;
          end else begin
            state_nxt = ST_REQ;
            sel_nxt   = dec_sel_s;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (slv_ready_s) begin
          state_nxt = ST_RESP;
          rdata_nxt = rd_r ? slv_rdata_s : ERR_RDATA;
        end else if (tmo_hit_s) begin
          state_nxt = ST_RESP;
          err_set_s = 1'b1;
        end else begin
          state_nxt = ST_REQ;
          sel_nxt   = sel_r;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and handshake output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sel_r   <= 2'b00;
      valid_r <= 1'b0;
      ready_r <= 1'b0;
      rdata_r <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nxt;
      sel_r   <= sel_nxt;
      valid_r <= (state_nxt == ST_REQ);
      ready_r <= (state_nxt == ST_RESP);
      rdata_r <= rdata_nxt;
    end
  end

  // Capture the command when it is accepted in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_r    <= 1'b0;
      rd_r    <= 1'b0;
      addr_r  <= {PC_SIZE{1'b0}};
      wdata_r <= {XLEN{1'b0}};
    end else if ((state_r == ST_IDLE) && ita_i_valid) begin
      wr_r    <= ita_i_wr;
      rd_r    <= ita_i_rd;
      addr_r  <= ita_i_addr;
      wdata_r <= ita_i_wdata;
    end
  end

  // Sticky error flag and first-error address; a new error beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r      <= 1'b0;
      err_addr_r <= {PC_SIZE{1'b0}};
    end else if (err_set_s) begin
      err_r <= 1'b1;
      if (!err_r || err_i_clr) begin
        err_addr_r <= err_addr_s;
      end
    end else if (err_i_clr) begin
      err_r      <= 1'b0;
      err_addr_r <= {PC_SIZE{1'b0}};
    end
  end

  assign ita_o_rdata       = rdata_r;
  assign ita_o_ready       = ready_r;
  assign slv_o_sel         = sel_r;
  assign slv_o_valid       = valid_r;
  assign slv_o_wr          = wr_r;
  assign slv_o_rd          = rd_r;
  assign slv_o_addr        = addr_r;
  assign slv_o_wdata       = wdata_r;
  assign bridge_o_err      = err_r;
  assign bridge_o_err_addr = err_addr_r;

endmodule

// File: tb/tb_ita_bridge.sv
// Self-checking bench for ita_bridge: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_ita_bridge;

  localparam int          TMO = 16;
  localparam logic [31:0] S0B = 32'h1000_0000;
  localparam logic [31:0] S0M = 32'hFFFF_F000;
  localparam logic [31:0] S1B = 32'h1000_1000;
  localparam logic [31:0] S1M = 32'hFFFF_F000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ita_i_valid = 1'b0, ita_i_wr = 1'b0, ita_i_rd = 1'b0;
  logic [31:0] ita_i_addr = 32'h0, ita_i_wdata = 32'h0;
  logic [31:0] ita_o_rdata;
  logic        ita_o_ready;
  logic [1:0]  slv_o_sel;
  logic        slv_o_valid, slv_o_wr, slv_o_rd;
  logic [31:0] slv_o_addr, slv_o_wdata;
  logic [31:0] slv0_i_rdata = 32'h0, slv1_i_rdata = 32'h0;
  logic        slv0_i_ready = 1'b0, slv1_i_ready = 1'b0;
  logic        err_i_clr = 1'b0;
  logic        bridge_o_err;
  logic [31:0] bridge_o_err_addr;

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference model of the sticky error registers
  logic        err_m = 1'b0;
  logic [31:0] err_addr_m = 32'h0;

  always #5 clk = ~clk;

  ita_bridge #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ita_i_valid(ita_i_valid), .ita_i_wr(ita_i_wr), .ita_i_rd(ita_i_rd),
    .ita_i_addr(ita_i_addr), .ita_i_wdata(ita_i_wdata),
    .ita_o_rdata(ita_o_rdata), .ita_o_ready(ita_o_ready),
    .slv_o_sel(slv_o_sel), .slv_o_valid(slv_o_valid),
    .slv_o_wr(slv_o_wr), .slv_o_rd(slv_o_rd),
    .slv_o_addr(slv_o_addr), .slv_o_wdata(slv_o_wdata),
    .slv0_i_rdata(slv0_i_rdata), .slv1_i_rdata(slv1_i_rdata),
    .slv0_i_ready(slv0_i_ready), .slv1_i_ready(slv1_i_ready),
    .err_i_clr(err_i_clr),
    .bridge_o_err(bridge_o_err), .bridge_o_err_addr(bridge_o_err_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One LSU transaction; lat = number of REQ cycles before the slave answers
  task automatic do_txn(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat,
                        input logic [31:0] srd, input logic clr_with);
    logic [1:0]  esel;
    logic        is_err, got;
    logic [31:0] exp_rd;
    int          exp_lat, exp_req, n, reqc;
    if ((addr & S0M) == S0B)      esel = 2'b01;
    else if ((addr & S1M) == S1B) esel = 2'b10;
    else                          esel = 2'b00;
    is_err  = (wr == rd) || (esel == 2'b00);
    exp_req = is_err ? 0 : lat + 1;
    exp_lat = is_err ? 1 : lat + 2;
`ifdef ITA_TIMEOUT_EN
    if (!is_err && lat >= TMO) begin
      is_err  = 1'b1;
      exp_req = TMO;
      exp_lat = TMO + 1;
    end
`endif
    exp_rd = (is_err || !rd) ? 32'h0 : srd;

    @(posedge clk); #1;
    chk("ready_pulse", {63'h0, ita_o_ready}, 64'h0);
    ita_i_valid = 1'b1; ita_i_wr = wr; ita_i_rd = rd;
    ita_i_addr = addr; ita_i_wdata = wdata; err_i_clr = clr_with;
    n = 0; reqc = 0; got = 1'b0;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      err_i_clr    = 1'b0;
      slv0_i_ready = 1'b0;
      slv1_i_ready = 1'b0;
      slv0_i_rdata = $urandom;
      slv1_i_rdata = $urandom;
      if (ita_o_ready) begin
        got = 1'b1;
      end else if (slv_o_valid) begin
        chk("req_sel", {62'h0, slv_o_sel}, {62'h0, esel});
        chk("req_addr", {32'h0, slv_o_addr}, {32'h0, addr});
        chk("req_wdata", {32'h0, slv_o_wdata}, {32'h0, wdata});
        chk("req_cmd", {62'h0, slv_o_wr, slv_o_rd}, {62'h0, wr, rd});
        // unselected slave babbles; it must be ignored
        if (esel == 2'b01) slv1_i_ready = 1'($urandom);
        else               slv0_i_ready = 1'($urandom);
        if (reqc == lat) begin
          if (esel == 2'b01) begin slv0_i_ready = 1'b1; slv0_i_rdata = srd; end
          else               begin slv1_i_ready = 1'b1; slv1_i_rdata = srd; end
        end
        reqc++;
      end
    end
    chk("done", {63'h0, got}, 64'h1);
    chk("latency", 64'(n), 64'(exp_lat));
    chk("req_cycles", 64'(reqc), 64'(exp_req));
    chk("rdata", {32'h0, ita_o_rdata}, {32'h0, exp_rd});
    chk("valid_in_resp", {63'h0, slv_o_valid}, 64'h0);
    if (clr_with) begin
      err_m = 1'b0; err_addr_m = 32'h0;
    end
    if (is_err) begin
      if (!err_m) err_addr_m = addr;
      err_m = 1'b1;
    end
    chk("err_flag", {63'h0, bridge_o_err}, {63'h0, err_m});
    chk("err_addr", {32'h0, bridge_o_err_addr}, {32'h0, err_addr_m});
    ita_i_valid = 1'b0; ita_i_wr = 1'b0; ita_i_rd = 1'b0;
    slv0_i_ready = 1'b0; slv1_i_ready = 1'b0;
  endtask

  task automatic do_clr();
    @(posedge clk); #1;
    err_i_clr = 1'b1;
    @(posedge clk); #1;
    err_i_clr = 1'b0;
    err_m = 1'b0; err_addr_m = 32'h0;
    chk("clr_flag", {63'h0, bridge_o_err}, 64'h0);
    chk("clr_addr", {32'h0, bridge_o_err_addr}, 64'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic        w, r;
    int          cat, cmd;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'h0, ita_o_ready}, 64'h0);
    chk("rst_valid", {63'h0, slv_o_valid}, 64'h0);
    chk("rst_sel", {62'h0, slv_o_sel}, 64'h0);
    chk("rst_err", {63'h0, bridge_o_err}, 64'h0);
    chk("rst_err_addr", {32'h0, bridge_o_err_addr}, 64'h0);
    chk("rst_rdata", {32'h0, ita_o_rdata}, 64'h0);
    rst = 1'b0;

    // directed scenarios
    do_txn(1'b0, 1'b1, 32'h1000_0004, 32'h0, 0, 32'hA5A5_0001, 1'b0);
    do_txn(1'b1, 1'b0, 32'h1000_1008, 32'h1234_5678, 3, 32'hDEAD_BEEF, 1'b0);
    do_txn(1'b0, 1'b1, 32'h2000_0000, 32'h0, 0, 32'h0, 1'b0);
    do_txn(1'b0, 1'b1, 32'h3000_0000, 32'h0, 0, 32'h0, 1'b0);
    chk("first_err_kept", {32'h0, bridge_o_err_addr}, 64'h2000_0000);
    do_clr();
    do_txn(1'b1, 1'b1, 32'h1000_0010, 32'h0, 0, 32'h0, 1'b0);
    do_clr();
    do_txn(1'b0, 1'b1, 32'h2000_0040, 32'h0, 0, 32'h0, 1'b0);
    do_txn(1'b0, 1'b0, 32'h4000_0080, 32'h0, 0, 32'h0, 1'b1);
    chk("clr_vs_err", {32'h0, bridge_o_err_addr}, 64'h4000_0080);
    do_clr();
`ifdef ITA_TIMEOUT_EN
    do_txn(1'b0, 1'b1, 32'h1000_0020, 32'h0, TMO - 1, 32'h0BAD_F00D, 1'b0);
    do_txn(1'b0, 1'b1, 32'h1000_1020, 32'h0, 1000, 32'h0, 1'b0);
    do_clr();
`endif

    // reset asserted between clock edges during REQ
    @(posedge clk); #1;
    ita_i_valid = 1'b1; ita_i_rd = 1'b1; ita_i_wr = 1'b0;
    ita_i_addr = 32'h1000_0100;
    @(posedge clk); #1;
    chk("pre_rst_valid", {63'h0, slv_o_valid}, 64'h1);
    @(posedge clk); #3;
    rst = 1'b1;
    ita_i_valid = 1'b0; ita_i_rd = 1'b0;
    #1;
    chk("arst_valid", {63'h0, slv_o_valid}, 64'h0);
    chk("arst_sel", {62'h0, slv_o_sel}, 64'h0);
    chk("arst_ready", {63'h0, ita_o_ready}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    err_m = 1'b0; err_addr_m = 32'h0;
    do_txn(1'b0, 1'b1, 32'h1000_0104, 32'h0, 1, 32'h5A5A_1234, 1'b0);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      cat = $urandom_range(0, 3);
      case (cat)
        0:       a = S0B | ($urandom & 32'h0000_0FFF);
        1:       a = S1B | ($urandom & 32'h0000_0FFF);
        2:       a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
        default: a = $urandom;
      endcase
      cmd = $urandom_range(0, 9);
      if (cmd < 4)      begin w = 1'b0; r = 1'b1; end
      else if (cmd < 8) begin w = 1'b1; r = 1'b0; end
      else if (cmd == 8) begin w = 1'b1; r = 1'b1; end
      else              begin w = 1'b0; r = 1'b0; end
      do_txn(w, r, a, $urandom, $urandom_range(0, 5), $urandom,
             ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 15) == 0) do_clr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
